// File: rtl/ram_memory_controller_if.sv
// RAM-side bus between the cache system (master) and the backing store.
// Carries request, write data, read data, completion and counters.
interface ram_memory_controller_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int COUNTER_WIDTH = 32
);
   logic [ADDRESS_WIDTH-1:0] address;
   logic                     readEnabled;
   logic                     writeEnabled;
   logic [DATA_WIDTH-1:0]    dataOut;
   logic [DATA_WIDTH-1:0]    dataIn;
   logic                     functionComplete;
   logic                     busy;
   logic [COUNTER_WIDTH-1:0] readCount;
   logic [COUNTER_WIDTH-1:0] writeCount;

   modport master (
      output address,
      output readEnabled,
      output writeEnabled,
      output dataOut,
      input  dataIn,
      input  functionComplete,
      input  busy,
      input  readCount,
      input  writeCount
   );

   modport slave (
      input  address,
      input  readEnabled,
      input  writeEnabled,
      input  dataOut,
      output dataIn,
      output functionComplete,
      output busy,
      output readCount,
      output writeCount
   );
endinterface

// File: rtl/ram_memory_controller.sv
// Backing-store RAM slave with fixed multi-cycle read/write latency
// and saturating completed-transaction counters.
module ram_memory_controller #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 4,
   parameter int COUNTER_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   ram_memory_controller_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam logic [7:0] RD_M1 = 8'(READ_LATENCY - 1);
   localparam logic [7:0] WR_M1 = 8'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      READ_WAIT,
      WRITE_WAIT,
      COMPLETE
   } state_e;

   state_e                   state_q, state_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    data_q, data_d;
   logic                     rd_q, rd_d;
   logic                     wr_q, wr_d;
   logic [DATA_WIDTH-1:0]    din_q, din_d;
   logic                     fc_q, fc_d;
   logic                     busy_q, busy_d;
   logic [COUNTER_WIDTH-1:0] rcnt_q, rcnt_d;
   logic [COUNTER_WIDTH-1:0] wcnt_q, wcnt_d;

   logic                     mem_we;
   logic                     req;
   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [DATA_WIDTH-1:0]    mem_rdata;

   assign req       = bus.readEnabled | bus.writeEnabled;
   assign mem_rdata = mem[addr_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      din_d   = din_q;
      rcnt_d  = rcnt_q;
      wcnt_d  = wcnt_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               addr_d = bus.address;
               data_d = bus.dataOut;
               rd_d   = bus.readEnabled;
               wr_d   = bus.writeEnabled;
               if (bus.writeEnabled) begin
                  state_d = WRITE_WAIT;
                  cnt_d   = WR_M1;
               end else begin
                  state_d = READ_WAIT;
                  cnt_d   = RD_M1;
               end
            end
         end
         READ_WAIT, WRITE_WAIT: begin
            // Dropping both enables before commit abandons the op.
            if (!req) begin
               state_d = IDLE;
            end else if (cnt_q == 8'd0) begin
               state_d = COMPLETE;
               if (wr_q) begin
                  mem_we = 1'b1;
                  if (!(&wcnt_q)) wcnt_d = wcnt_q + 1'b1;
               end
               if (rd_q) begin
                  if (!(&rcnt_q)) rcnt_d = rcnt_q + 1'b1;
                  din_d = wr_q ? data_q : mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         COMPLETE: begin
            if (!req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == READ_WAIT) ||
               (state_d == WRITE_WAIT);
      fc_d   = (state_d == COMPLETE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         din_q   <= '0;
         fc_q    <= 1'b0;
         busy_q  <= 1'b0;
         rcnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         din_q   <= din_d;
         fc_q    <= fc_d;
         busy_q  <= busy_d;
         rcnt_q  <= rcnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Storage survives reset; only the controller state is cleared.
   always_ff @(posedge clock) begin
      if (mem_we) mem[addr_q] <= data_q;
   end

   assign bus.dataIn           = din_q;
   assign bus.functionComplete = fc_q;
   assign bus.busy             = busy_q;
   assign bus.readCount        = rcnt_q;
   assign bus.writeCount       = wcnt_q;
endmodule
